load_store_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational load/store unit.
- Sits between the LS reservation station and the RRF, R_CZ, store buffer, ROB and L1d cache.
- Adds a valid/ready issue handshake, a registered address stage, and variable-latency L1d with miss wait.
- Adds flush with orphan-response drain, and registered writeback.

---
 rtl/ls_pkg.sv | 34 +++
 rtl/ls_wb_reg.sv | 93 +++++++++
 rtl/load_store_pipe.sv | 195 +++++++++++++++++++
 tb/tb_load_store_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared types for the pipelined load/store unit: FSM encoding,
// issue bundle at the default configuration, and default widths.
package ls_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int PREG_W_DEF    = 7;
    localparam int AREG_W_DEF    = 3;
    localparam int ZREG_W_DEF    = 8;
    localparam int SB_IDX_W_DEF  = 5;
    localparam int ROB_IDX_W_DEF = 7;
    localparam int PC_AREG_DEF   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } ls_state_e;

    // One issue from the LS reservation station at the default widths.
    typedef struct packed {
        logic                     store;
        logic [DATA_W_DEF-1:0]    base;
        logic [DATA_W_DEF-1:0]    offset;
        logic [DATA_W_DEF-1:0]    src;
        logic [PREG_W_DEF-1:0]    dest;
        logic [AREG_W_DEF-1:0]    arch_dest;
        logic [ZREG_W_DEF-1:0]    z_dest;
        logic [SB_IDX_W_DEF-1:0]  sb_index;
        logic [ROB_IDX_W_DEF-1:0] rob_index;
        logic                     lmsm;
    } ls_issue_t;

endpackage

// File: rtl/ls_wb_reg.sv
// Writeback output register: turns a completing op into one-cycle RRF/R_CZ/SB/ROB/redirect pulses.
// Latency: 1 cycle from completion to pulse.
// Backpressure: none; flush in the completion cycle suppresses the pulse.
module ls_wb_reg
    import ls_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PREG_W    = PREG_W_DEF,
    parameter int AREG_W    = AREG_W_DEF,
    parameter int ZREG_W    = ZREG_W_DEF,
    parameter int SB_IDX_W  = SB_IDX_W_DEF,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int PC_AREG   = PC_AREG_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 cmp_vld,
    input  logic                 cmp_store,
    input  logic                 cmp_lmsm,
    input  logic [DATA_W-1:0]    cmp_addr,
    input  logic [DATA_W-1:0]    cmp_dat,
    input  logic [PREG_W-1:0]    cmp_dest,
    input  logic [AREG_W-1:0]    cmp_arch_dest,
    input  logic [ZREG_W-1:0]    cmp_z_dest,
    input  logic [SB_IDX_W-1:0]  cmp_sb_index,
    input  logic [ROB_IDX_W-1:0] cmp_rob_index,
    output logic                 SB_W,
    output logic [SB_IDX_W-1:0]  SB_index_out,
    output logic [DATA_W-1:0]    SB_addr_out,
    output logic [DATA_W-1:0]    SB_data_out,
    output logic                 LS_W,
    output logic [PREG_W-1:0]    LS_RR,
    output logic [DATA_W-1:0]    LS_D,
    output logic                 LS_Z_W,
    output logic [ZREG_W-1:0]    LS_Z_dest,
    output logic                 LS_Z,
    output logic                 ROB_W,
    output logic [ROB_IDX_W-1:0] ROB_index_out,
    output logic                 LS_branch_mispred,
    output logic [DATA_W-1:0]    LS_new_PC
);

    logic wb_vld;
    logic st_vld;
    logic ld_vld;
    logic pc_vld;
    logic rf_vld;
    logic z_vld;

    assign wb_vld = cmp_vld & ~flush;
    assign st_vld = wb_vld & cmp_store;
    assign ld_vld = wb_vld & ~cmp_store;
    // A load into the PC alias redirects fetch instead of writing the RRF.
    assign pc_vld = ld_vld & (cmp_arch_dest == AREG_W'(PC_AREG));
    assign rf_vld = ld_vld & ~pc_vld;
    assign z_vld  = ld_vld & ~cmp_lmsm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SB_W              <= 1'b0;
            SB_index_out      <= '0;
            SB_addr_out       <= '0;
            SB_data_out       <= '0;
            LS_W              <= 1'b0;
            LS_RR             <= '0;
            LS_D              <= '0;
            LS_Z_W            <= 1'b0;
            LS_Z_dest         <= '0;
            LS_Z              <= 1'b0;
            ROB_W             <= 1'b0;
            ROB_index_out     <= '0;
            LS_branch_mispred <= 1'b0;
            LS_new_PC         <= '0;
        end else begin
            SB_W              <= st_vld;
            SB_index_out      <= st_vld ? cmp_sb_index : '0;
            SB_addr_out       <= st_vld ? cmp_addr : '0;
            SB_data_out       <= st_vld ? cmp_dat : '0;
            LS_W              <= rf_vld;
            LS_RR             <= rf_vld ? cmp_dest : '0;
            LS_D              <= rf_vld ? cmp_dat : '0;
            LS_Z_W            <= z_vld;
            LS_Z_dest         <= z_vld ? cmp_z_dest : '0;
            LS_Z              <= z_vld & (cmp_dat == '0);
            ROB_W             <= wb_vld;
            ROB_index_out     <= wb_vld ? cmp_rob_index : '0;
            LS_branch_mispred <= pc_vld;
            LS_new_PC         <= pc_vld ? cmp_dat : '0;
        end
    end

endmodule

// File: rtl/load_store_pipe.sv
// Pipelined load/store unit: registered address stage, SB forward, L1d miss wait, flush drain.
// Latency: store / SB-hit load 2 cycles issue->writeback; miss 1 cycle after L1d response.
// Backpressure: in_ready low while a miss is outstanding, during flush and while draining.
module load_store_pipe
    import ls_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PREG_W    = PREG_W_DEF,
    parameter int AREG_W    = AREG_W_DEF,
    parameter int ZREG_W    = ZREG_W_DEF,
    parameter int SB_IDX_W  = SB_IDX_W_DEF,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int PC_AREG   = PC_AREG_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_store,
    input  logic [DATA_W-1:0]    in_base,
    input  logic [DATA_W-1:0]    in_offset,
    input  logic [DATA_W-1:0]    in_src,
    input  logic [PREG_W-1:0]    in_dest,
    input  logic [AREG_W-1:0]    in_arch_dest,
    input  logic [ZREG_W-1:0]    in_z_dest,
    input  logic [SB_IDX_W-1:0]  in_sb_index,
    input  logic [ROB_IDX_W-1:0] in_rob_index,
    input  logic                 in_lmsm,
    input  logic                 flush,
    output logic [DATA_W-1:0]    SB_search_addr,
    input  logic                 SB_match,
    input  logic [DATA_W-1:0]    SB_data,
    output logic                 L1d_req,
    output logic [DATA_W-1:0]    L1d_addr,
    input  logic                 L1d_rsp_valid,
    input  logic [DATA_W-1:0]    L1d_data,
    output logic                 SB_W,
    output logic [SB_IDX_W-1:0]  SB_index_out,
    output logic [DATA_W-1:0]    SB_addr_out,
    output logic [DATA_W-1:0]    SB_data_out,
    output logic                 LS_W,
    output logic [PREG_W-1:0]    LS_RR,
    output logic [DATA_W-1:0]    LS_D,
    output logic                 LS_Z_W,
    output logic [ZREG_W-1:0]    LS_Z_dest,
    output logic                 LS_Z,
    output logic                 ROB_W,
    output logic [ROB_IDX_W-1:0] ROB_index_out,
    output logic                 LS_branch_mispred,
    output logic [DATA_W-1:0]    LS_new_PC
);

    // S1 holds the effective address rather than base/offset.
    typedef struct packed {
        logic                 store;
        logic                 lmsm;
        logic [DATA_W-1:0]    addr;
        logic [DATA_W-1:0]    src;
        logic [PREG_W-1:0]    dest;
        logic [AREG_W-1:0]    arch_dest;
        logic [ZREG_W-1:0]    z_dest;
        logic [SB_IDX_W-1:0]  sb_index;
        logic [ROB_IDX_W-1:0] rob_index;
    } s1_t;

    ls_state_e         state_q;
    ls_state_e         state_d;
    s1_t               s1_q;
    logic [DATA_W-1:0] eff_addr;
    logic              cmp_vld;
    logic              accept;
    logic [DATA_W-1:0] ld_dat;
    logic [DATA_W-1:0] cmp_dat;

    assign eff_addr = in_base + in_offset;

    assign cmp_vld = ((state_q == EXEC) && (s1_q.store || SB_match)) ||
                     ((state_q == WAIT) && L1d_rsp_valid);

    assign in_ready = ~flush & (state_q != DRAIN) & ((state_q == IDLE) | cmp_vld);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = cmp_vld ? (accept ? EXEC : IDLE) : WAIT;
            WAIT:    if (L1d_rsp_valid) state_d = accept ? EXEC : IDLE;
            DRAIN:   if (L1d_rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // An outstanding read must still be absorbed after flush, or its
        // response would be taken for the next miss.
        if (flush) begin
            if ((state_q == WAIT) && !L1d_rsp_valid) begin
                state_d = DRAIN;
            end else if (state_q != DRAIN) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        SB_search_addr = '0;
        L1d_req        = 1'b0;
        L1d_addr       = '0;
        unique case (state_q)
            EXEC: begin
                if (!s1_q.store) begin
                    SB_search_addr = s1_q.addr;
                    if (!SB_match && !flush) begin
                        L1d_req  = 1'b1;
                        L1d_addr = s1_q.addr;
                    end
                end
            end
            WAIT: begin
                if (!flush || L1d_rsp_valid) begin
                    L1d_req  = 1'b1;
                    L1d_addr = s1_q.addr;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (flush) begin
            s1_q <= '0;
        end else if (accept) begin
            s1_q <= '{store:     in_store,
                      lmsm:      in_lmsm,
                      addr:      eff_addr,
                      src:       in_src,
                      dest:      in_dest,
                      arch_dest: in_arch_dest,
                      z_dest:    in_z_dest,
                      sb_index:  in_sb_index,
                      rob_index: in_rob_index};
        end
    end

    assign ld_dat  = (state_q == WAIT) ? L1d_data : SB_data;
    assign cmp_dat = s1_q.store ? s1_q.src : ld_dat;

    ls_wb_reg #(
        .DATA_W    (DATA_W),
        .PREG_W    (PREG_W),
        .AREG_W    (AREG_W),
        .ZREG_W    (ZREG_W),
        .SB_IDX_W  (SB_IDX_W),
        .ROB_IDX_W (ROB_IDX_W),
        .PC_AREG   (PC_AREG)
    ) u_wb_reg (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .cmp_vld           (cmp_vld),
        .cmp_store         (s1_q.store),
        .cmp_lmsm          (s1_q.lmsm),
        .cmp_addr          (s1_q.addr),
        .cmp_dat           (cmp_dat),
        .cmp_dest          (s1_q.dest),
        .cmp_arch_dest     (s1_q.arch_dest),
        .cmp_z_dest        (s1_q.z_dest),
        .cmp_sb_index      (s1_q.sb_index),
        .cmp_rob_index     (s1_q.rob_index),
        .SB_W              (SB_W),
        .SB_index_out      (SB_index_out),
        .SB_addr_out       (SB_addr_out),
        .SB_data_out       (SB_data_out),
        .LS_W              (LS_W),
        .LS_RR             (LS_RR),
        .LS_D              (LS_D),
        .LS_Z_W            (LS_Z_W),
        .LS_Z_dest         (LS_Z_dest),
        .LS_Z              (LS_Z),
        .ROB_W             (ROB_W),
        .ROB_index_out     (ROB_index_out),
        .LS_branch_mispred (LS_branch_mispred),
        .LS_new_PC         (LS_new_PC)
    );

endmodule

// File: tb/tb_load_store_pipe.sv
// Directed + randomized bench for load_store_pipe against a rules-level writeback model.
module tb_load_store_pipe;
    import ls_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_store, in_lmsm, flush;
    logic [15:0] in_base, in_offset, in_src;
    logic [6:0]  in_dest;
    logic [2:0]  in_arch_dest;
    logic [7:0]  in_z_dest;
    logic [4:0]  in_sb_index;
    logic [6:0]  in_rob_index;
    logic [15:0] SB_search_addr, SB_data, L1d_addr, L1d_data;
    logic        SB_match, L1d_req, L1d_rsp_valid;
    logic        SB_W, LS_W, LS_Z_W, LS_Z, ROB_W, LS_branch_mispred;
    logic [4:0]  SB_index_out;
    logic [15:0] SB_addr_out, SB_data_out, LS_D, LS_new_PC;
    logic [6:0]  LS_RR, ROB_index_out;
    logic [7:0]  LS_Z_dest;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_store(in_store), .in_base(in_base), .in_offset(in_offset), .in_src(in_src),
        .in_dest(in_dest), .in_arch_dest(in_arch_dest), .in_z_dest(in_z_dest),
        .in_sb_index(in_sb_index), .in_rob_index(in_rob_index), .in_lmsm(in_lmsm),
        .flush(flush), .SB_search_addr(SB_search_addr), .SB_match(SB_match), .SB_data(SB_data),
        .L1d_req(L1d_req), .L1d_addr(L1d_addr), .L1d_rsp_valid(L1d_rsp_valid), .L1d_data(L1d_data),
        .SB_W(SB_W), .SB_index_out(SB_index_out), .SB_addr_out(SB_addr_out), .SB_data_out(SB_data_out),
        .LS_W(LS_W), .LS_RR(LS_RR), .LS_D(LS_D), .LS_Z_W(LS_Z_W), .LS_Z_dest(LS_Z_dest), .LS_Z(LS_Z),
        .ROB_W(ROB_W), .ROB_index_out(ROB_index_out),
        .LS_branch_mispred(LS_branch_mispred), .LS_new_PC(LS_new_PC)
    );

    logic [96:0] wb_obs;
    assign wb_obs = {SB_W, SB_index_out, SB_addr_out, SB_data_out, LS_W, LS_RR, LS_D,
                     LS_Z_W, LS_Z_dest, LS_Z, ROB_W, ROB_index_out, LS_branch_mispred, LS_new_PC};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ea(input ls_issue_t o);
        return 16'((int'(o.base) + int'(o.offset)) % 65536);
    endfunction

    // Expected writeback bundle, straight from the completion rules.
    function automatic logic [96:0] exp_wb(input ls_issue_t o, input logic [15:0] data);
        logic ld = !o.store;
        logic pc = ld && (o.arch_dest == 3'd0);
        logic rf = ld && !pc;
        logic zw = ld && !o.lmsm;
        return {o.store, o.store ? o.sb_index : 5'd0, o.store ? ea(o) : 16'd0,
                o.store ? o.src : 16'd0,
                rf, rf ? o.dest : 7'd0, rf ? data : 16'd0,
                zw, zw ? o.z_dest : 8'd0, zw && (data == 16'd0),
                1'b1, o.rob_index, pc, pc ? data : 16'd0};
    endfunction

    function automatic ls_issue_t rand_op(input logic st);
        ls_issue_t o;
        o.store     = st;
        o.base      = 16'($urandom);
        o.offset    = 16'($urandom);
        o.src       = 16'($urandom);
        o.dest      = 7'($urandom);
        o.arch_dest = 3'($urandom);
        o.z_dest    = 8'($urandom);
        o.sb_index  = 5'($urandom);
        o.rob_index = 7'($urandom);
        o.lmsm      = 1'($urandom);
        return o;
    endfunction

    function automatic logic [15:0] rand_dat();
        return ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic clear_issue();
        in_valid = 1'b0; in_store = 1'b0; in_base = '0; in_offset = '0; in_src = '0;
        in_dest = '0; in_arch_dest = '0; in_z_dest = '0; in_sb_index = '0;
        in_rob_index = '0; in_lmsm = 1'b0;
    endtask

    task automatic drive_op(input ls_issue_t o);
        in_valid = 1'b1; in_store = o.store; in_base = o.base; in_offset = o.offset;
        in_src = o.src; in_dest = o.dest; in_arch_dest = o.arch_dest; in_z_dest = o.z_dest;
        in_sb_index = o.sb_index; in_rob_index = o.rob_index; in_lmsm = o.lmsm;
    endtask

    // lat=0: store or SB hit; lat>=2: L1d_req high for lat cycles, response in the last.
    task automatic run_op(input string tag, input ls_issue_t o, input int lat, input logic [15:0] data);
        drive_op(o);
        samp();
        chk({tag, ".issue_rdy"}, 128'(in_ready), 128'(1'b1));
        chk({tag, ".issue_wb"}, 128'(wb_obs), 128'(0));
        next_cyc();
        clear_issue();
        SB_match = !o.store && (lat == 0);
        SB_data  = (lat == 0) ? data : 16'($urandom);
        samp();
        if (!o.store) chk({tag, ".sb_addr"}, 128'(SB_search_addr), 128'(ea(o)));
        chk({tag, ".exec_req"}, 128'(L1d_req), 128'(lat != 0));
        chk({tag, ".exec_rdy"}, 128'(in_ready), 128'(lat == 0));
        if (lat != 0) chk({tag, ".exec_l1addr"}, 128'(L1d_addr), 128'(ea(o)));
        next_cyc();
        for (int c = 1; c < lat; c++) begin
            SB_match = 1'($urandom);
            SB_data  = 16'($urandom);
            if (c == lat - 1) begin
                L1d_rsp_valid = 1'b1;
                L1d_data      = data;
            end
            samp();
            chk({tag, ".wait_req"}, 128'(L1d_req), 128'(1'b1));
            chk({tag, ".wait_addr"}, 128'(L1d_addr), 128'(ea(o)));
            chk({tag, ".wait_rdy"}, 128'(in_ready), 128'(c == lat - 1));
            chk({tag, ".wait_wb"}, 128'(wb_obs), 128'(0));
            next_cyc();
            L1d_rsp_valid = 1'b0;
            L1d_data      = '0;
        end
        SB_match = 1'b0;
        SB_data  = '0;
        samp();
        chk({tag, ".wb"}, 128'(wb_obs), 128'(exp_wb(o, data)));
        next_cyc();
        samp();
        chk({tag, ".wb_pulse"}, 128'(wb_obs), 128'(0));
        next_cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ls_issue_t   o, o2;
        ls_issue_t   b[6];
        logic [15:0] bd[6];

        clear_issue();
        flush = 1'b0; SB_match = 1'b0; SB_data = '0; L1d_rsp_valid = 1'b0; L1d_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        samp();
        chk("rst.wb", 128'(wb_obs), 128'(0));
        chk("rst.req", 128'(L1d_req), 128'(0));
        chk("rst.l1addr", 128'(L1d_addr), 128'(0));
        chk("rst.sbaddr", 128'(SB_search_addr), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        samp();
        chk("rst.rdy", 128'(in_ready), 128'(1'b1));
        next_cyc();

        o = '0; o.store = 1'b1; o.base = 16'h0010; o.offset = 16'h0004; o.src = 16'hBEEF;
        o.sb_index = 5'd3; o.rob_index = 7'd5;
        run_op("store", o, 0, 16'h0000);

        o = rand_op(1'b0); o.base = 16'hFFFF; o.offset = 16'h0002; o.arch_dest = 3'd2;
        o.dest = 7'd9; o.lmsm = 1'b0;
        run_op("ld_wrap_hit", o, 0, 16'h0000);

        o = rand_op(1'b0); o.arch_dest = 3'd0; o.lmsm = 1'b0;
        run_op("ld_pc_miss", o, 4, 16'h1234);

        for (int i = 0; i < 12; i++) begin
            int kind = $urandom_range(0, 2);
            o = rand_op(kind == 0);
            run_op($sformatf("rnd%0d", i), o, (kind == 2) ? $urandom_range(2, 6) : 0, rand_dat());
        end

        // Flush while a miss is outstanding; response comes three cycles later.
        o  = rand_op(1'b0);
        o2 = rand_op(1'b0);
        drive_op(o);
        next_cyc();
        clear_issue();
        samp();
        next_cyc();
        flush = 1'b1;
        samp();
        chk("fl_wait.rdy", 128'(in_ready), 128'(0));
        chk("fl_wait.req", 128'(L1d_req), 128'(0));
        next_cyc();
        flush = 1'b0;
        drive_op(o2);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                L1d_rsp_valid = 1'b1;
                L1d_data      = 16'($urandom);
            end
            samp();
            chk("drain.rdy", 128'(in_ready), 128'(0));
            chk("drain.req", 128'(L1d_req), 128'(0));
            chk("drain.wb", 128'(wb_obs), 128'(0));
            next_cyc();
            L1d_rsp_valid = 1'b0;
            L1d_data      = '0;
        end
        run_op("after_drain", o2, 3, rand_dat());

        // Flush in the same cycle as the response.
        o = rand_op(1'b0);
        drive_op(o);
        next_cyc();
        clear_issue();
        samp();
        next_cyc();
        flush = 1'b1; L1d_rsp_valid = 1'b1; L1d_data = 16'($urandom);
        samp();
        chk("fl_rsp.rdy", 128'(in_ready), 128'(0));
        next_cyc();
        flush = 1'b0; L1d_rsp_valid = 1'b0; L1d_data = '0;
        samp();
        chk("fl_rsp.wb", 128'(wb_obs), 128'(0));
        chk("fl_rsp.rdy_after", 128'(in_ready), 128'(1'b1));
        chk("fl_rsp.req_after", 128'(L1d_req), 128'(0));
        next_cyc();

        // Flush with in_valid: the load must not be taken.
        o = rand_op(1'b0);
        drive_op(o);
        flush = 1'b1;
        samp();
        chk("fl_issue.rdy", 128'(in_ready), 128'(0));
        next_cyc();
        flush = 1'b0;
        clear_issue();
        samp();
        chk("fl_issue.req", 128'(L1d_req), 128'(0));
        chk("fl_issue.sbaddr", 128'(SB_search_addr), 128'(0));
        next_cyc();
        samp();
        chk("fl_issue.wb", 128'(wb_obs), 128'(0));
        next_cyc();

        // Flush while a store is completing suppresses its writeback.
        o = rand_op(1'b1);
        drive_op(o);
        next_cyc();
        clear_issue();
        flush = 1'b1;
        samp();
        next_cyc();
        flush = 1'b0;
        samp();
        chk("fl_store.wb", 128'(wb_obs), 128'(0));
        next_cyc();

        // Back-to-back completions at one op per cycle.
        for (int i = 0; i < 6; i++) begin
            b[i]  = rand_op((i >= 2) ? 1'($urandom) : 1'b0);
            bd[i] = rand_dat();
        end
        b[0].lmsm = 1'b0; b[0].arch_dest = 3'd4;
        b[1].lmsm = 1'b1; b[1].arch_dest = 3'd5;
        for (int i = 0; i < 8; i++) begin
            clear_issue();
            SB_match = 1'b0;
            SB_data  = '0;
            if (i < 6) drive_op(b[i]);
            if (i >= 1 && i <= 6 && !b[i-1].store) begin
                SB_match = 1'b1;
                SB_data  = bd[i-1];
            end
            samp();
            if (i < 6) chk($sformatf("b2b%0d.rdy", i), 128'(in_ready), 128'(1'b1));
            if (i >= 1 && i <= 6 && !b[i-1].store)
                chk($sformatf("b2b%0d.sbaddr", i), 128'(SB_search_addr), 128'(ea(b[i-1])));
            if (i >= 2) chk($sformatf("b2b%0d.wb", i), 128'(wb_obs), 128'(exp_wb(b[i-2], bd[i-2])));
            next_cyc();
        end
        SB_match = 1'b0;
        SB_data  = '0;
        samp();
        chk("b2b.idle_wb", 128'(wb_obs), 128'(0));
        next_cyc();

        // Reset while waiting on L1d, then a stray response.
        o = rand_op(1'b0);
        drive_op(o);
        next_cyc();
        clear_issue();
        samp();
        next_cyc();
        samp();
        chk("rst_wait.req_before", 128'(L1d_req), 128'(1'b1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wait.req", 128'(L1d_req), 128'(0));
        chk("rst_wait.l1addr", 128'(L1d_addr), 128'(0));
        chk("rst_wait.wb", 128'(wb_obs), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        samp();
        chk("rst_wait.rdy", 128'(in_ready), 128'(1'b1));
        next_cyc();
        L1d_rsp_valid = 1'b1;
        L1d_data      = 16'($urandom);
        samp();
        chk("stray.req", 128'(L1d_req), 128'(0));
        next_cyc();
        L1d_rsp_valid = 1'b0;
        L1d_data      = '0;
        samp();
        chk("stray.wb", 128'(wb_obs), 128'(0));
        next_cyc();
        run_op("post_reset", rand_op(1'b0), 2, rand_dat());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
